// File: rtl/map_mem_arb.sv
// map_mem_arb: two-requester (A high priority, B starvation-guarded) arbiter for one memory port with ack timeout.
module map_mem_arb #(
  parameter int AW    = 23,
  parameter int MAX_A = 4,
  parameter int TOUT  = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  input  logic          a_we,
  input  logic [15:0]   a_wdat,
  output logic [15:0]   a_rdat,
  output logic          a_ack,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  input  logic          b_we,
  input  logic [15:0]   b_wdat,
  output logic [15:0]   b_rdat,
  output logic          b_ack,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [15:0]   mem_wdat,
  input  logic [15:0]   mem_rdat,
  input  logic          mem_ack,
  output logic          err,
  input  logic          err_clr
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic       owner;
  logic [3:0] starve;
  logic [7:0] tcnt;
  logic       grant, grant_b, tout_hit, fin;
  logic [15:0] rd;
  always_comb begin
    grant    = state == IDLE && (a_req || b_req);
    grant_b  = b_req && (!a_req || starve == 4'(MAX_A));
    tout_hit = state == BUSY && !mem_ack && tcnt == 8'(TOUT - 1);
    fin      = state == BUSY && (mem_ack || tout_hit);
    rd       = tout_hit ? 16'hFFFF : mem_rdat;
    state_n  = state == IDLE ? (grant ? BUSY : IDLE) :
               state == BUSY ? (fin ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner    <= 1'b0;
      starve   <= '0;
      tcnt     <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_we   <= 1'b0;
      mem_wdat <= '0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      a_rdat   <= '0;
      b_rdat   <= '0;
      err      <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      if (grant) begin
        owner    <= grant_b;
        mem_req  <= 1'b1;
        mem_addr <= grant_b ? b_addr : a_addr;
        mem_we   <= grant_b ? b_we : a_we;
        mem_wdat <= grant_b ? b_wdat : a_wdat;
        tcnt     <= '0;
        starve   <= grant_b ? 4'd0 : (b_req && starve != 4'(MAX_A)) ? starve + 4'd1 : starve;
      end
      if (state == BUSY) tcnt <= tcnt + 8'd1;
      if (fin) begin
        mem_req <= 1'b0;
        a_ack   <= !owner;
        b_ack   <= owner;
        if (!mem_we && owner) b_rdat <= rd;
        if (!mem_we && !owner) a_rdat <= rd;
      end
      if (tout_hit) err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end
endmodule
